lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_if.sv | 50 +++++
 rtl/lsu_load_fmt.sv | 34 +++
 rtl/lsu.sv | 162 ++++++++++++++++
 tb/tb_lsu.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg: shared definitions for the load/store unit.
//   - memop_e    : RISC-V funct3 size codes for loads and stores
//   - state_e    : LSU control FSM state encoding
//   - TO_CNT_W   : width of the WAIT-state timeout counter
//   - memop_legal / memop_misaligned : request screening helpers
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  // TIMEOUT must stay below 2**TO_CNT_W.
  localparam int unsigned TO_CNT_W = 16;

  typedef enum logic [2:0] {
    MEMOP_B  = 3'b000,
    MEMOP_H  = 3'b001,
    MEMOP_W  = 3'b010,
    MEMOP_BU = 3'b100,
    MEMOP_HU = 3'b101
  } memop_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Unsigned variants only make sense for loads; 011/110/111 are never legal.
  function automatic logic memop_legal(input logic [2:0] memop, input logic wen);
    case (memop)
      MEMOP_B, MEMOP_H, MEMOP_W: return 1'b1;
      MEMOP_BU, MEMOP_HU:        return !wen;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic logic memop_misaligned(input logic [2:0] memop, input logic [1:0] byte_off);
    case (memop)
      MEMOP_H, MEMOP_HU: return byte_off[0];
      MEMOP_W:           return byte_off != 2'b00;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces of the load/store unit.
//   lsu_req_if : core <-> LSU request/response channel
//                master = core, slave = LSU
//   lsu_mem_if : LSU <-> memory word-aligned request/response channel
//                master = LSU, slave = memory
// -----------------------------------------------------------------------------
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [2:0]  req_memop;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_memop, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_memop, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/lsu_load_fmt.sv
// -----------------------------------------------------------------------------
// lsu_load_fmt: combinational load-data formatter.
//   memop    in  3   funct3 size code of the load
//   byte_off in  2   byte offset of the access within the word
//   rdata    in  32  raw memory word
//   data     out 32  word shifted down to the access, sign/zero-extended
// -----------------------------------------------------------------------------
module lsu_load_fmt
  import lsu_pkg::*;
(
  input  logic [2:0]  memop,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves it unassigned, which would infer a latch.
    data    = '0;
    shifted = rdata >> {byte_off, 3'b000};
    case (memop)
      MEMOP_B:  data = {{24{shifted[7]}},  shifted[7:0]};
      MEMOP_H:  data = {{16{shifted[15]}}, shifted[15:0]};
      MEMOP_W:  data = shifted;
      MEMOP_BU: data = {24'h0, shifted[7:0]};
      MEMOP_HU: data = {16'h0, shifted[15:0]};
      default:  data = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu: single-outstanding load/store unit between a core and a word memory.
//   clk   in   single clock, rising edge
//   rst   in   synchronous active-high reset
//   core  lsu_req_if.slave   request (valid/ready, wen, addr, memop, wdata)
//                            and response (valid/ready, rdata, err)
//   mem   lsu_mem_if.master  word-aligned request with byte mask, and a
//                            one-cycle response pulse per request
// Flow: IDLE -> REQ (memory handshake) -> WAIT (response or timeout) -> RESP.
// Illegal or misaligned requests skip memory and go straight to an error RESP.
// -----------------------------------------------------------------------------
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  lsu_req_if.slave     core,
  lsu_mem_if.master    mem
);

  state_e              state_q, state_d;
  logic [TO_CNT_W-1:0] cnt_q,   cnt_d;
  logic                wen_q,   wen_d;
  logic [31:0]         addr_q,  addr_d;
  logic [2:0]          memop_q, memop_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q,   err_d;

  logic [31:0]         fmt_rdata;

  lsu_load_fmt u_load_fmt (
    .memop    (memop_q),
    .byte_off (addr_q[1:0]),
    .rdata    (mem.mem_rsp_rdata),
    .data     (fmt_rdata)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      memop_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      memop_q <= memop_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    memop_d = memop_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (core.req_valid) begin
          if (!memop_legal(core.req_memop, core.req_wen) ||
              memop_misaligned(core.req_memop, core.req_addr[1:0])) begin
            state_d = ST_RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = ST_REQ;
            wen_d   = core.req_wen;
            addr_d  = core.req_addr;
            memop_d = core.req_memop;
            wdata_d = core.req_wdata;
          end
        end
      end

      ST_REQ: begin
        if (mem.mem_req_ready) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end

      ST_WAIT: begin
        // A response in the final cycle still wins over the timeout.
        if (mem.mem_rsp_valid) begin
          state_d = ST_RESP;
          rdata_d = wen_q ? 32'h0 : fmt_rdata;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TO_CNT_W'(TIMEOUT)) begin
            state_d = ST_RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end

      ST_RESP: begin
        if (core.resp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Store lanes: the access size is memop[1:0] (00 byte, 01 half, 10 word);
  // narrow store data is replicated so every enabled lane sees the right bytes.
  logic [3:0]  wmask;
  logic [31:0] wdata_lanes;

  always_comb begin
    wmask       = '0;
    wdata_lanes = '0;
    if (wen_q) begin
      case (memop_q[1:0])
        2'b00: begin
          wmask       = 4'b0001 << addr_q[1:0];
          wdata_lanes = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          wmask       = 4'b0011 << addr_q[1:0];
          wdata_lanes = {2{wdata_q[15:0]}};
        end
        default: begin
          wmask       = 4'b1111;
          wdata_lanes = wdata_q;
        end
      endcase
    end
  end

  assign core.req_ready  = (state_q == ST_IDLE);
  assign core.resp_valid = (state_q == ST_RESP);
  assign core.resp_rdata = rdata_q;
  assign core.resp_err   = err_q;

  // Driven purely from captured registers, so they hold steady across stalls.
  assign mem.mem_req_valid = (state_q == ST_REQ);
  assign mem.mem_wen       = wen_q;
  assign mem.mem_addr      = {addr_q[31:2], 2'b00};
  assign mem.mem_wdata     = wdata_lanes;
  assign mem.mem_wmask     = wmask;

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu: self-checking bench for lsu. Inputs change and outputs are sampled
// on the falling clock edge. Expected values come from a behavioural model
// written in terms of access sizes and byte arithmetic.
// -----------------------------------------------------------------------------
module tb_lsu;

  localparam int T_OUT = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lsu_req_if core_bus ();
  lsu_mem_if mem_bus ();

  lsu #(.TIMEOUT(T_OUT)) dut (
    .clk  (clk),
    .rst  (rst),
    .core (core_bus),
    .mem  (mem_bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int ref_size(input logic [2:0] op);
    case (op)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit ref_illegal(input bit wen, input logic [31:0] addr, input logic [2:0] op);
    int n;
    n = ref_size(op);
    if (n == 0) return 1'b1;
    if (wen && op[2]) return 1'b1;
    return (addr % n) != 0;
  endfunction

  function automatic logic [3:0] ref_wmask(input bit wen, input logic [31:0] addr, input logic [2:0] op);
    int n;
    if (!wen) return 4'h0;
    n = ref_size(op);
    return 4'(((1 << n) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input bit wen, input logic [31:0] wdata, input logic [2:0] op);
    int n;
    logic [31:0] r;
    r = '0;
    if (!wen) return r;
    n = ref_size(op);
    for (int i = 0; i < 4; i++)
      r = r | (((wdata >> (8 * (i % n))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] word);
    int n;
    longint unsigned v, span;
    n    = ref_size(op);
    v    = longint'(word) >> (8 * (addr % 4));
    span = longint'(1) << (8 * n);
    v    = v % span;
    if (!op[2] && n < 4 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // ---------------- helpers ----------------
  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"},  core_bus.req_ready,     1);
    check({tag, "_resp_valid"}, core_bus.resp_valid,    0);
    check({tag, "_resp_err"},   core_bus.resp_err,      0);
    check({tag, "_resp_rdata"}, core_bus.resp_rdata,    0);
    check({tag, "_mem_valid"},  mem_bus.mem_req_valid,  0);
    check({tag, "_mem_wen"},    mem_bus.mem_wen,        0);
    check({tag, "_mem_addr"},   mem_bus.mem_addr,       0);
    check({tag, "_mem_wdata"},  mem_bus.mem_wdata,      0);
    check({tag, "_mem_wmask"},  mem_bus.mem_wmask,      0);
  endtask

  task automatic check_mem(input bit wen, input logic [31:0] addr, input logic [2:0] op, input logic [31:0] wdata);
    check("mem_req_valid", mem_bus.mem_req_valid, 1);
    check("mem_wen",       mem_bus.mem_wen,       wen);
    check("mem_addr",      mem_bus.mem_addr,      addr & 32'hFFFF_FFFC);
    check("mem_wmask",     mem_bus.mem_wmask,     ref_wmask(wen, addr, op));
    check("mem_wdata",     mem_bus.mem_wdata,     ref_wdata(wen, wdata, op));
    check("req_ready_busy", core_bus.req_ready,   0);
  endtask

  // One full transaction from IDLE back to IDLE with the given stalls.
  task automatic do_txn(input bit wen, input logic [31:0] addr, input logic [2:0] op,
                        input logic [31:0] wdata, input logic [31:0] word,
                        input int mem_stall, input int rsp_delay, input int resp_stall,
                        input bit no_rsp);
    bit          bad;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          n_resp;
    bad = ref_illegal(wen, addr, op);
    check("idle_req_ready", core_bus.req_ready, 1);
    core_bus.req_valid = 1'b1;
    core_bus.req_wen   = wen;
    core_bus.req_addr  = addr;
    core_bus.req_memop = op;
    core_bus.req_wdata = wdata;
    @(negedge clk);
    // Scramble request fields so the DUT must rely on its captured copy.
    core_bus.req_valid = 1'b0;
    core_bus.req_wen   = $urandom_range(0, 1);
    core_bus.req_addr  = $urandom;
    core_bus.req_memop = 3'($urandom_range(0, 7));
    core_bus.req_wdata = $urandom;
    if (bad) begin
      exp_err   = 1'b1;
      exp_rdata = '0;
    end else begin
      for (int k = 0; k < mem_stall; k++) begin
        // Stray response during REQ must be ignored.
        mem_bus.mem_rsp_valid = (k == 0);
        mem_bus.mem_rsp_rdata = $urandom;
        check_mem(wen, addr, op, wdata);
        @(negedge clk);
      end
      mem_bus.mem_rsp_valid = 1'b0;
      mem_bus.mem_req_ready = 1'b1;
      check_mem(wen, addr, op, wdata);
      @(negedge clk);
      mem_bus.mem_req_ready = 1'b0;
      if (no_rsp) begin
        for (int d = 0; d < T_OUT; d++) begin
          check("timeout_wait_no_resp", core_bus.resp_valid,   0);
          check("timeout_wait_no_mreq", mem_bus.mem_req_valid, 0);
          @(negedge clk);
        end
        exp_err   = 1'b1;
        exp_rdata = '0;
      end else begin
        for (int d = 0; d < rsp_delay; d++) begin
          check("wait_no_resp", core_bus.resp_valid, 0);
          @(negedge clk);
        end
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_rdata = word;
        @(negedge clk);
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rsp_rdata = $urandom;
        exp_err   = 1'b0;
        exp_rdata = wen ? 32'h0 : ref_load(addr, op, word);
      end
    end
    n_resp = 0;
    for (int r = 0; r <= resp_stall; r++) begin
      check("resp_valid", core_bus.resp_valid, 1);
      check("resp_rdata", core_bus.resp_rdata, exp_rdata);
      check("resp_err",   core_bus.resp_err,   exp_err);
      check("resp_no_mreq", mem_bus.mem_req_valid, 0);
      check("resp_req_ready", core_bus.req_ready, 0);
      core_bus.resp_ready = (r == resp_stall);
      if (core_bus.resp_valid && core_bus.resp_ready) n_resp++;
      @(negedge clk);
    end
    core_bus.resp_ready = 1'b0;
    check("one_response", n_resp, 1);
    check("post_resp_valid", core_bus.resp_valid, 0);
    check("post_req_ready",  core_bus.req_ready,  1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] legal_ops [5];
    logic [2:0] op;
    logic [31:0] addr;
    bit wen;
    legal_ops[0] = 3'd0; legal_ops[1] = 3'd1; legal_ops[2] = 3'd2;
    legal_ops[3] = 3'd4; legal_ops[4] = 3'd5;

    core_bus.req_valid  = 1'b0;
    core_bus.req_wen    = 1'b0;
    core_bus.req_addr   = '0;
    core_bus.req_memop  = '0;
    core_bus.req_wdata  = '0;
    core_bus.resp_ready = 1'b0;
    mem_bus.mem_req_ready = 1'b0;
    mem_bus.mem_rsp_valid = 1'b0;
    mem_bus.mem_rsp_rdata = '0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("reset");

    // Stray response while idle must be ignored.
    mem_bus.mem_rsp_valid = 1'b1;
    mem_bus.mem_rsp_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_bus.mem_rsp_valid = 1'b0;
    check("idle_rsp_ignored", core_bus.resp_valid, 0);

    // Directed vectors
    do_txn(1, 32'h8000_0003, 3'd0, 32'h0000_00AB, 32'h0, 0, 0, 0, 0);  // SB
    do_txn(0, 32'h8000_0001, 3'd0, 32'h0, 32'h0000_F100, 0, 0, 0, 0);  // LB
    check("lb_vector", ref_load(32'h8000_0001, 3'd0, 32'h0000_F100), 32'hFFFF_FFF1);
    do_txn(0, 32'h8000_0001, 3'd4, 32'h0, 32'h0000_F100, 0, 0, 0, 0);  // LBU
    do_txn(0, 32'h8000_0002, 3'd1, 32'h0, 32'h8001_0000, 0, 0, 0, 0);  // LH
    do_txn(0, 32'h8000_0002, 3'd2, 32'h0, 32'h0, 0, 0, 0, 0);          // LW misaligned
    do_txn(1, 32'h0000_0010, 3'd4, 32'h1234_5678, 32'h0, 0, 0, 0, 0);  // SBU illegal
    do_txn(0, 32'h0000_0010, 3'd3, 32'h0, 32'h0, 0, 0, 0, 0);          // code 011
    do_txn(1, 32'h0000_0102, 3'd1, 32'hCAFE_BEEF, 32'h0, 5, 1, 3, 0);  // SH with stalls
    do_txn(0, 32'h0000_0204, 3'd2, 32'h0, 32'h1357_9BDF, 5, 0, 3, 0);  // LW with stalls
    do_txn(0, 32'h0000_0300, 3'd2, 32'h0, 32'h0, 0, 0, 0, 1);          // timeout
    do_txn(0, 32'h0000_0303, 3'd0, 32'h0, 32'h8000_0000, 0, T_OUT - 1, 0, 0); // late-but-in-time

    // Reset while in WAIT, followed by a late memory response.
    core_bus.req_valid = 1'b1;
    core_bus.req_wen   = 1'b0;
    core_bus.req_addr  = 32'h0000_0400;
    core_bus.req_memop = 3'd2;
    @(negedge clk);
    core_bus.req_valid    = 1'b0;
    mem_bus.mem_req_ready = 1'b1;
    @(negedge clk);
    mem_bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_bus.mem_rsp_valid = 1'b1;
    mem_bus.mem_rsp_rdata = 32'hA5A5_A5A5;
    check_idle_outputs("after_rst");
    @(negedge clk);
    mem_bus.mem_rsp_valid = 1'b0;
    check("late_rsp_no_resp", core_bus.resp_valid, 0);
    check("late_rsp_ready",   core_bus.req_ready,  1);
    do_txn(0, 32'h0000_0404, 3'd5, 32'h0, 32'h8765_4321, 0, 0, 0, 0);

    // Randomized transactions
    for (int t = 0; t < 60; t++) begin
      wen = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) op = 3'($urandom_range(0, 7));
      else op = legal_ops[$urandom_range(0, 4)];
      addr = $urandom;
      do_txn(wen, addr, op, $urandom, $urandom,
             $urandom_range(0, 2), $urandom_range(0, T_OUT - 1),
             $urandom_range(0, 2), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
